mat_row_read_arbiter: RTL and testbench
=======================================

Name: mat_row_read_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 8x8 matrix row memory's Avalon-MM read slave (64-bit rows, one outstanding read, variable latency).
- Each requester asks for a burst of consecutive rows. The block grants one requester, issues single-row Avalon reads back to back and routes each returned row to the granted requester.
- Sits between the matrix consumers (e.g. MAC/systolic front ends) and the memory wrapper.

Parameters:
NUM_ROWS, 8, rows in matrix; row index wraps modulo NUM_ROWS (power of 2)
ADDR_W, 32, Avalon address width
DATA_W, 64, row width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  2  per-requester burst request, level, held until grant
row_base0  in  3  requester 0 start row
row_cnt0  in  4  requester 0 row count
row_base1  in  3  requester 1 start row
row_cnt1  in  4  requester 1 row count
grant  out  2  one-hot, high for whole burst
rd_data  out  DATA_W  returned row, registered
rd_valid  out  2  one-cycle pulse on bit of granted requester when rd_data valid
done  out  2  one-cycle pulse at burst end
err  out  1  one-cycle pulse on watchdog abort
busy  out  1  high when state != IDLE
avm_address  out  ADDR_W  row index, zero-extended
avm_read  out  1  Avalon read strobe
avm_readdata  in  DATA_W  slave read data
avm_readdatavalid  in  1  slave data valid
avm_waitrequest  in  1  slave busy

Behaviour:
- Reset (async, any state, including mid-burst): all outputs 0. State IDLE. RR pointer favours requester 0 next. Remaining count 0.
- States: IDLE, ISSUE, WAIT_DATA, DONE.
- IDLE:
  - Arbitrate among req bits. If one is set, pick it. If both are set, pick the one not granted last (pointer).
  - Latch base/cnt, set grant bit, go to ISSUE.
  - Count: 0 -> go to DONE directly, no reads. Values >8 clamp to NUM_ROWS.
- ISSUE:
  - Drive avm_read=1 and avm_address=current row.
  - If avm_waitrequest=0 this cycle, the read is accepted: go to WAIT_DATA, avm_read=0 next cycle.
  - Otherwise hold avm_read and avm_address stable.
- WAIT_DATA:
  - avm_read=0. On avm_readdatavalid: rd_data<=avm_readdata and rd_valid[g]=1 on the next cycle. Row advances by 1 modulo NUM_ROWS (base 6, cnt 4 -> rows 6,7,0,1). Remaining decrements.
  - Remaining reaches 0 -> DONE, else ISSUE.
  - Never more than one outstanding read.
- DONE (one cycle): done[g]=1, grant cleared, pointer = g. Return to IDLE. A new grant can be issued no earlier than the cycle after DONE.
- rd_data holds its last value between pulses.
- req deassertion mid-burst is ignored; the burst completes. req from the non-granted requester waits.
- avm_readdatavalid outside WAIT_DATA (stale) is dropped. No rd_valid is generated for it.
- Per-row latency = slave latency + 1 cycle output register. Burst overhead = 2 cycles (arbitrate + DONE).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DATA. If TIMEOUT_CYCLES cycles pass with no avm_readdatavalid, abort the burst.
  - On abort: err=1 and done[g]=1 in the same cycle, no rd_valid, remaining cleared, go to IDLE, pointer updated.
  - Counter resets on each entry to WAIT_DATA.
  - The next ISSUE still honours avm_waitrequest.
- Undefined: WAIT_DATA waits indefinitely; err tied 0; no counter logic.

Test Plan:
- Single requester: req=01, base0=0, cnt0=8, slave latency 12 -> rows 0..7 in order on rd_data, 8 rd_valid[0] pulses, one read per row, done[0] once, grant=01 throughout.
- Wrap: req=10, base1=6, cnt1=4 -> avm_address sequence 6,7,0,1, done[1] after the 4th rd_valid.
- Contention: req=11 from reset -> requester 0 bursts first, then requester 1. Repeat with req held at 11 -> grants alternate 01,10,01.
- Boundaries: cnt=0 -> done pulse, no avm_read. cnt=15 -> exactly 8 reads. avm_waitrequest held high 5 cycles during ISSUE -> avm_read/address stable for 5 cycles, single acceptance.
- Reset mid-burst at row 3 -> all outputs 0 next cycle. A late readdatavalid after release is dropped. A fresh req=01 burst completes correctly.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, slave never returns data -> err and done[0] pulse 64 cycles after acceptance, busy=0 next cycle.

Source files
------------

// File: rtl/mat_row_read_arbiter.sv
// mat_row_read_arbiter
//
// Two-requester round-robin arbiter and read sequencer in front of the matrix
// row memory's Avalon-MM read slave. The winning requester gets a burst of
// consecutive rows. The rows wrap modulo NUM_ROWS. Each row is a single Avalon
// read, and only one read is outstanding at a time. Each returned row is
// registered and steered to the granted requester.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog aborts a burst when the
// slave does not return data within TIMEOUT_CYCLES cycles of accepting a read.
// The abort pulses err together with done. When the macro is undefined,
// WAIT_DATA waits indefinitely and err is tied low.
//
// Ports:
//   clk                clock, all logic on the rising edge
//   reset              asynchronous, active-high reset
//   req[1:0]           per-requester burst request (level, held until grant)
//   row_base0/1        start row of requester 0/1
//   row_cnt0/1         row count of requester 0/1 (0 = empty burst, >NUM_ROWS clamps)
//   grant[1:0]         one-hot, high for the whole burst including the DONE cycle
//   rd_data            last returned row (registered, holds between pulses)
//   rd_valid[1:0]      one-cycle pulse on the granted requester's bit with rd_data
//   done[1:0]          one-cycle pulse on the granted requester's bit at burst end
//   err                one-cycle watchdog abort pulse (0 without ARB_TIMEOUT_EN)
//   busy               high whenever the sequencer is not IDLE
//   avm_address        current row index, zero-extended to ADDR_W
//   avm_read           Avalon read strobe
//   avm_readdata       slave read data
//   avm_readdatavalid  slave read data valid
//   avm_waitrequest    slave stall
//   dbg_state          current FSM state (IDLE=0, ISSUE=1, WAIT_DATA=2, DONE=3)
//
// Handshake: the Avalon master side follows read/waitrequest semantics.
// avm_read and avm_address are held stable from the first ISSUE cycle until
// a rising edge at which avm_waitrequest is low. That edge transfers the read.
// Data is then accepted only in WAIT_DATA on avm_readdatavalid. A
// readdatavalid at any other time is stale and is dropped. On the requester
// side, req acts as a "valid" that must stay high until grant. Deasserting req
// after the grant does not cancel the burst.

module mat_row_read_arbiter #(
  parameter int NUM_ROWS       = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req,
  input  logic [$clog2(NUM_ROWS)-1:0] row_base0,
  input  logic [3:0]                  row_cnt0,
  input  logic [$clog2(NUM_ROWS)-1:0] row_base1,
  input  logic [3:0]                  row_cnt1,
  output logic [1:0]                  grant,
  output logic [DATA_W-1:0]           rd_data,
  output logic [1:0]                  rd_valid,
  output logic [1:0]                  done,
  output logic                        err,
  output logic                        busy,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_waitrequest,
  output logic [1:0]                  dbg_state
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  // Enough bits to hold NUM_ROWS itself (a full-matrix burst).
  localparam int REM_W = ROW_W + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ROW_W-1:0]   row;
  logic [REM_W-1:0]   remaining;
  // Requester that won last. Reset to 1 so requester 0 is favoured first.
  logic               last_g;

  logic               pick;
  logic [ROW_W-1:0]   sel_base;
  logic [3:0]         sel_cnt;
  logic [REM_W-1:0]   sel_cnt_clamped;
  logic               abort;

  // ---------------------------------------------------------------------------
  // Arbitration (evaluated only in IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_g;
      default: pick = 1'b0;
    endcase
  end

  always_comb begin
    sel_base = pick ? row_base1 : row_base0;
    sel_cnt  = pick ? row_cnt1  : row_cnt0;
    if (int'(sel_cnt) > NUM_ROWS) begin
      sel_cnt_clamped = REM_W'(NUM_ROWS);
    end else begin
      sel_cnt_clamped = REM_W'(sel_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Every WAIT_DATA entry comes from ISSUE. Clearing the counter in ISSUE
  // therefore restarts the count for each accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT_DATA) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT_DATA cycle if data has still not come.
  assign abort = (state == S_WAIT_DATA) && !avm_readdatavalid &&
                 (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nx = (sel_cnt_clamped == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!avm_waitrequest) begin
          state_nx = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (avm_readdatavalid) begin
          state_nx = (remaining == REM_W'(1)) ? S_DONE : S_ISSUE;
        end else if (abort) begin
          state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grant     <= 2'b00;
      last_g    <= 1'b1;
      row       <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 2'b00;
    end else begin
      state    <= state_nx;
      rd_valid <= 2'b00;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant     <= pick ? 2'b10 : 2'b01;
            row       <= sel_base;
            remaining <= sel_cnt_clamped;
          end
        end
        S_WAIT_DATA: begin
          if (avm_readdatavalid) begin
            rd_data   <= avm_readdata;
            rd_valid  <= grant;
            // Power-of-two NUM_ROWS: the natural wrap of row gives modulo.
            row       <= row + ROW_W'(1);
            remaining <= remaining - REM_W'(1);
          end else if (abort) begin
            grant     <= 2'b00;
            last_g    <= grant[1];
            remaining <= '0;
          end
        end
        S_DONE: begin
          grant  <= 2'b00;
          last_g <= grant[1];
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign avm_read    = (state == S_ISSUE);
  assign avm_address = (state == S_ISSUE) ? ADDR_W'(row) : '0;
  assign busy        = (state != S_IDLE);
  // grant is still set during DONE and during the abort cycle, so it selects the done bit.
  assign done        = ((state == S_DONE) || abort) ? grant : 2'b00;
  assign err         = abort;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mat_row_read_arbiter.sv
module tb_mat_row_read_arbiter;

  localparam int W = 65;  // {requester, row data}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [2:0]  row_base0 = '0, row_base1 = '0;
  logic [3:0]  row_cnt0 = '0, row_cnt1 = '0;
  logic [1:0]  grant, rd_valid, done, dbg_state;
  logic [63:0] rd_data;
  logic        err, busy;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_row_read_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .row_base0(row_base0), .row_cnt0(row_cnt0),
    .row_base1(row_base1), .row_cnt1(row_cnt1),
    .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .err(err), .busy(busy), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .dbg_state(dbg_state)
  );

  // ---------------- Avalon slave model ----------------
  logic [63:0] mem [8];
  int          slave_lat = 4;   // 0 = never return data
  int          wr_mode = 0;     // 0 never stall, 1 random stall, 2 stall first stall_left cycles
  int          stall_left = 0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          n_reads = 0;
  int          accept_cyc = 0;
  logic [31:0] obs_addr[$];

  initial begin
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = {$urandom, $urandom};
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem[pend_addr[2:0]];
        end
      end
      case (wr_mode)
        1: avm_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (avm_read && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
          end
        end
        default: avm_waitrequest = 1'b0;
      endcase
      #1;
      if (avm_read && !avm_waitrequest) begin
        pend_addr = avm_address;
        n_reads++;
        obs_addr.push_back(avm_address);
        accept_cyc = cyc;
        if (slave_lat > 0) lat_cnt = slave_lat;
      end
    end
  end

  // ---------------- monitor (records only) ----------------
  logic [W-1:0] obs_rdv[$];
  logic [1:0]   obs_done[$];
  logic [1:0]   obs_grants[$];
  int           rdv_cyc = 0, done_cyc = 0, err_cyc = 0, n_err = 0, n_err_total = 0;
  int           gb_bad = 0, stall_cycles = 0, stall_move = 0;
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [1:0]   prev_grant = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd_valid != 2'b00) begin
        obs_rdv.push_back({rd_valid[1], rd_data});
        rdv_cyc = cyc;
        if (rd_valid != grant) gb_bad++;
      end
      if (done != 2'b00) begin
        obs_done.push_back(done);
        done_cyc = cyc;
      end
      if (err) begin
        n_err++;
        n_err_total++;
        err_cyc = cyc;
      end
      if (grant != 2'b00 && prev_grant == 2'b00) obs_grants.push_back(grant);
      if (grant != 2'b00 && grant != 2'b01 && grant != 2'b10) gb_bad++;
      if ((grant != 2'b00) != busy) gb_bad++;
      if (avm_read && avm_waitrequest) stall_cycles++;
      if (avm_read && prev_stall && avm_address != prev_addr) stall_move++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      prev_grant = grant;
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int           exp_addr[$];
  logic [1:0]   exp_done[$];
  int           model_last = 1;  // requester granted last; 1 after reset favours 0

  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (model_last == 1) ? 0 : 1;
  endfunction

  task automatic model_burst(input int r, input int base, input int cnt);
    int n;
    logic rb;
    n  = (cnt > 8) ? 8 : cnt;
    rb = (r != 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({rb, mem[(base + i) % 8]});
      exp_addr.push_back((base + i) % 8);
    end
    exp_done.push_back(rb ? 2'b10 : 2'b01);
    model_last = r;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic clear_logs();
    obs_rdv.delete(); obs_done.delete(); obs_grants.delete(); obs_addr.delete();
    exp_q.delete(); exp_addr.delete(); exp_done.delete();
    n_reads = 0; n_err = 0; gb_bad = 0; stall_cycles = 0; stall_move = 0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) step();
    reset = 1'b0;
    model_last = 1;
    step();
  endtask

  // Raise req, drop it once granted, wait for the done pulse (bounded).
  task automatic issue_req(input logic [1:0] r, input int budget);
    int n0, k;
    n0 = obs_done.size();
    k = 0;
    req = r;
    while (grant == 2'b00 && k < budget) begin step(); k++; end
    req = 2'b00;
    while (obs_done.size() == n0 && k < budget) begin step(); k++; end
    checks++;
    if (obs_done.size() == n0) begin
      failures++;
      $display("FAIL burst_bound req=%b no done within %0d cycles", r, budget);
    end
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({grant, rd_valid, done, err, busy, avm_read} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {grant, rd_valid, done, err, busy, avm_read});
    end
    checks++;
    if (avm_address !== 32'd0) begin
      failures++; $display("FAIL reset_addr got=%0h exp=0", avm_address);
    end
    checks++;
    if (rd_data !== 64'd0) begin
      failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data);
    end
    reset = 1'b0;
    model_last = 1;
    repeat (2) step();
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL idle_after_reset busy=%b grant=%b exp 0/00", busy, grant);
    end
  endtask

  task automatic test_single_burst();
    fill_mem(); clear_logs();
    slave_lat = 12; wr_mode = 0;
    row_base0 = 3'd0; row_cnt0 = 4'd8;
    model_burst(0, 0, 8);
    issue_req(2'b01, 400);
    checks++;
    if (obs_rdv.size() != exp_q.size()) begin
      failures++; $display("FAIL single_rdv_count got=%0d exp=%0d", obs_rdv.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL single_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
    checks++;
    if (n_reads != 8) begin failures++; $display("FAIL single_reads got=%0d exp=8", n_reads); end
    checks++;
    if (obs_done.size() != 1 || obs_done[0] !== 2'b01) begin
      failures++; $display("FAIL single_done count=%0d exp=1 of 01", obs_done.size());
    end
    checks++;
    if (obs_grants.size() != 1 || obs_grants[0] !== 2'b01 || gb_bad != 0) begin
      failures++; $display("FAIL single_grant grants=%0d bad=%0d exp 1 grant of 01, 0 bad", obs_grants.size(), gb_bad);
    end
    repeat (3) step();
    checks++;
    if (rd_data !== mem[7] || rd_valid !== 2'b00) begin
      failures++; $display("FAIL single_hold rd_data=%h exp=%h rd_valid=%b", rd_data, mem[7], rd_valid);
    end
  endtask

  task automatic test_wrap();
    fill_mem(); clear_logs();
    slave_lat = $urandom_range(1, 5); wr_mode = 1;
    row_base1 = 3'd6; row_cnt1 = 4'd4;
    model_burst(1, 6, 4);
    issue_req(2'b10, 400);
    checks++;
    if (obs_addr.size() != 4) begin failures++; $display("FAIL wrap_reads got=%0d exp=4", obs_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== 32'(exp_addr[i])) begin
        failures++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    checks++;
    if (obs_rdv.size() != 4) begin failures++; $display("FAIL wrap_rdv_count got=%0d exp=4", obs_rdv.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL wrap_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_done.size() != 1 || obs_done[0] !== 2'b10 || done_cyc < rdv_cyc) begin
      failures++; $display("FAIL wrap_done count=%0d done_cyc=%0d last_rdv_cyc=%0d", obs_done.size(), done_cyc, rdv_cyc);
    end
  endtask

  task automatic test_contention();
    int b0, c0, b1, c1, k, g;
    do_reset();
    fill_mem(); clear_logs();
    slave_lat = $urandom_range(1, 4); wr_mode = 1;
    b0 = $urandom_range(0, 7); c0 = $urandom_range(1, 8);
    b1 = $urandom_range(0, 7); c1 = $urandom_range(1, 8);
    row_base0 = 3'(b0); row_cnt0 = 4'(c0); row_base1 = 3'(b1); row_cnt1 = 4'(c1);
    for (int i = 0; i < 4; i++) begin
      g = model_pick(2'b11);
      model_burst(g, (g == 0) ? b0 : b1, (g == 0) ? c0 : c1);
    end
    req = 2'b11;
    k = 0;
    while (obs_grants.size() < 4 && k < 1500) begin step(); k++; end
    req = 2'b00;
    while (obs_done.size() < 4 && k < 1500) begin step(); k++; end
    checks++;
    if (obs_done.size() < 4) begin failures++; $display("FAIL cont_bound done=%0d exp=4", obs_done.size()); end
    step();
    for (int i = 0; i < 4 && i < obs_grants.size() && i < obs_done.size(); i++) begin
      checks++;
      if (obs_grants[i] !== exp_done[i] || obs_done[i] !== exp_done[i]) begin
        failures++; $display("FAIL cont_order%0d grant=%b done=%b exp=%b", i, obs_grants[i], obs_done[i], exp_done[i]);
      end
    end
    checks++;
    if (obs_rdv.size() != exp_q.size()) begin
      failures++; $display("FAIL cont_rdv_count got=%0d exp=%0d", obs_rdv.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL cont_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    int b;
    fill_mem(); clear_logs();
    slave_lat = 3; wr_mode = 0;
    // empty burst
    row_base0 = 3'd5; row_cnt0 = 4'd0;
    model_burst(0, 5, 0);
    issue_req(2'b01, 50);
    checks++;
    if (n_reads != 0 || obs_rdv.size() != 0 || obs_done.size() != 1 || obs_done[0] !== 2'b01) begin
      failures++; $display("FAIL cnt0 reads=%0d rdv=%0d done=%0d exp 0/0/1", n_reads, obs_rdv.size(), obs_done.size());
    end
    // count above NUM_ROWS clamps
    clear_logs();
    b = $urandom_range(0, 7);
    row_base1 = 3'(b); row_cnt1 = 4'd15;
    model_burst(1, b, 15);
    issue_req(2'b10, 400);
    checks++;
    if (n_reads != 8 || obs_rdv.size() != 8) begin
      failures++; $display("FAIL cnt15 reads=%0d rdv=%0d exp=8", n_reads, obs_rdv.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL cnt15_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
    // waitrequest held 5 cycles
    clear_logs();
    wr_mode = 2; stall_left = 5;
    b = $urandom_range(0, 7);
    row_base0 = 3'(b); row_cnt0 = 4'd1;
    model_burst(0, b, 1);
    issue_req(2'b01, 100);
    checks++;
    if (stall_cycles != 5 || stall_move != 0 || n_reads != 1) begin
      failures++; $display("FAIL stall stall_cycles=%0d moves=%0d reads=%0d exp 5/0/1", stall_cycles, stall_move, n_reads);
    end
    checks++;
    if (obs_rdv.size() != 1 || obs_rdv[0] !== exp_q[0]) begin
      failures++; $display("FAIL stall_row got_count=%0d exp=%h", obs_rdv.size(), exp_q[0]);
    end
    wr_mode = 0;
  endtask

  task automatic test_random_rounds();
    logic [1:0] r;
    int b0, c0, b1, c1, g;
    fill_mem(); clear_logs();
    wr_mode = 1;
    for (int n = 0; n < 12; n++) begin
      slave_lat = $urandom_range(1, 6);
      r  = 2'($urandom_range(1, 3));
      b0 = $urandom_range(0, 7); c0 = $urandom_range(0, 15);
      b1 = $urandom_range(0, 7); c1 = $urandom_range(0, 15);
      row_base0 = 3'(b0); row_cnt0 = 4'(c0); row_base1 = 3'(b1); row_cnt1 = 4'(c1);
      g = model_pick(r);
      model_burst(g, (g == 0) ? b0 : b1, (g == 0) ? c0 : c1);
      issue_req(r, 600);
    end
    checks++;
    if (obs_done.size() != exp_done.size() || obs_grants.size() != exp_done.size()) begin
      failures++; $display("FAIL rand_bursts done=%0d grants=%0d exp=%0d", obs_done.size(), obs_grants.size(), exp_done.size());
    end
    for (int i = 0; i < exp_done.size() && i < obs_done.size() && i < obs_grants.size(); i++) begin
      checks++;
      if (obs_done[i] !== exp_done[i] || obs_grants[i] !== exp_done[i]) begin
        failures++; $display("FAIL rand_winner%0d grant=%b done=%b exp=%b", i, obs_grants[i], obs_done[i], exp_done[i]);
      end
    end
    checks++;
    if (obs_rdv.size() != exp_q.size() || obs_addr.size() != exp_addr.size() || gb_bad != 0) begin
      failures++; $display("FAIL rand_counts rdv=%0d/%0d reads=%0d/%0d bad=%0d", obs_rdv.size(), exp_q.size(), obs_addr.size(), exp_addr.size(), gb_bad);
    end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== 32'(exp_addr[i])) begin
        failures++; $display("FAIL rand_addr%0d got=%0d exp=%0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    wr_mode = 0;
  endtask

  task automatic test_reset_midburst();
    int k, b, c;
    do_reset();
    fill_mem(); clear_logs();
    slave_lat = 12; wr_mode = 0;
    row_base0 = 3'd0; row_cnt0 = 4'd8;
    req = 2'b01;
    k = 0;
    while (n_reads < 4 && k < 400) begin step(); k++; end
    req = 2'b00;
    checks++;
    if (n_reads < 4) begin failures++; $display("FAIL mid_bound reads=%0d exp=4", n_reads); end
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if ({grant, rd_valid, done, err, busy, avm_read} !== 9'b0 || avm_address !== 32'd0 || rd_data !== 64'd0) begin
      failures++; $display("FAIL mid_reset ctrl=%b addr=%0h rd_data=%h exp all 0",
                           {grant, rd_valid, done, err, busy, avm_read}, avm_address, rd_data);
    end
    step();
    reset = 1'b0;
    model_last = 1;
    clear_logs();
    repeat (15) step();
    checks++;
    if (obs_rdv.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL stale_drop rdv=%0d busy=%b exp 0/0", obs_rdv.size(), busy);
    end
    b = $urandom_range(0, 7); c = $urandom_range(1, 8);
    row_base0 = 3'(b); row_cnt0 = 4'(c);
    slave_lat = $urandom_range(1, 5);
    model_burst(0, b, c);
    issue_req(2'b01, 400);
    checks++;
    if (obs_rdv.size() != exp_q.size() || obs_done.size() != 1) begin
      failures++; $display("FAIL fresh_count rdv=%0d exp=%0d done=%0d", obs_rdv.size(), exp_q.size(), obs_done.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_rdv.size(); i++) begin
      checks++;
      if (obs_rdv[i] !== exp_q[i]) begin
        failures++; $display("FAIL fresh_row%0d got=%h exp=%h", i, obs_rdv[i], exp_q[i]);
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    fill_mem(); clear_logs();
    slave_lat = 0; wr_mode = 0;
    row_base0 = 3'd0; row_cnt0 = 4'd3;
    issue_req(2'b01, 200);
    checks++;
    if (n_err != 1 || err_cyc - accept_cyc != 64) begin
      failures++; $display("FAIL timeout_err count=%0d delay=%0d exp 1/64", n_err, err_cyc - accept_cyc);
    end
    checks++;
    if (obs_done.size() != 1 || obs_done[0] !== 2'b01 || done_cyc != err_cyc || obs_rdv.size() != 0) begin
      failures++; $display("FAIL timeout_done count=%0d done_cyc=%0d err_cyc=%0d rdv=%0d", obs_done.size(), done_cyc, err_cyc, obs_rdv.size());
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle busy=%b exp=0", busy); end
    slave_lat = 4;
  endtask
`else
  task automatic test_no_err();
    checks++;
    if (n_err_total != 0) begin failures++; $display("FAIL err_tied got=%0d pulses exp=0", n_err_total); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_contention();
    test_boundaries();
    test_random_rounds();
    test_reset_midburst();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
